is_uart_rx_ctrl: RTL and testbench
==================================

// Module: is_uart_rx_ctrl
// PURPOSE
//  Receive-side UART controller: sequences sampling of the already-synchronised RX line.
//  Detects the start bit, samples the data, parity and stop bits at mid-bit, and assembles bytes LSB-first.
//  Delivers each byte over a valid/ready handshake and flags framing, parity and overrun errors.
//  Sits between the RX synchroniser output and the byte consumer (FIFO/loopback logic).
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD_RATE   115_200     line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be >= 4)
//  DATA_BITS   8           data bits per frame, 5..8
//  PARITY_EN   0           1 = one parity bit after data
//  PARITY_ODD  0           1 = odd parity, 0 = even (ignored if PARITY_EN=0)
// PORTS
//  clk_i         in   1          system clock, rising edge
//  rst_i         in   1          asynchronous reset, active-high
//  uart_rxd_r_i  in   1          synchronised RX line, idle high
//  data_o        out  DATA_BITS  received byte, LSB = first bit on the line
//  valid_o       out  1          data_o holds an unconsumed byte
//  ready_i       in   1          consumer accepts data_o when valid_o & ready_i
//  frame_err_o   out  1          1-cycle pulse: stop bit sampled low
//  parity_err_o  out  1          1-cycle pulse: parity mismatch
//  overrun_o     out  1          1-cycle pulse: completed byte dropped because output still full
//  busy_o        out  1          high in every state except ARM/IDLE
// BEHAVIOUR
//  Reset (async, rst_i=1): state=ARM; data_o=0, valid_o=0, all error pulses=0, busy_o=0; counters=0.
//  Baud counter: width $clog2(CLKS_PER_BIT); reloads on every state change; "tick" = count reaches target.
//  States:
//   ARM     wait for uart_rxd_r_i=1 on one clock (the synchroniser resets its output low) -> IDLE.
//   IDLE    rxd_prev=1 & rxd=0 (falling edge) -> START, counter cleared.
//   START   after CLKS_PER_BIT/2 cycles sample: 0 -> DATA; 1 -> IDLE (glitch, no error, no output).
//   DATA    every CLKS_PER_BIT cycles sample into shift reg at index bit_cnt; after DATA_BITS samples
//           -> PARITY if PARITY_EN, else STOP.
//   PARITY  after CLKS_PER_BIT sample; compare to XOR(data)^PARITY_ODD; store the mismatch flag.
//   STOP    after CLKS_PER_BIT sample:
//           1 & no parity mismatch -> deliver, -> IDLE;
//           1 & mismatch -> parity_err_o pulse, byte discarded, -> IDLE;
//           0 -> frame_err_o pulse, byte discarded (frame error wins over parity), -> ARM.
//  Delivery: the cycle after the stop-bit sample, data_o loaded and valid_o=1.
//   Latency from the start-bit falling edge is CLKS_PER_BIT/2 + (DATA_BITS+PARITY_EN+1)*CLKS_PER_BIT + 1 cycles.
//  Handshake: valid_o stays high and data_o stays stable until the cycle valid_o & ready_i; valid_o clears the next cycle.
//   ready_i is ignored while valid_o=0.
//  Overrun: delivery while valid_o=1 & ready_i=0 -> new byte dropped, old byte kept, overrun_o pulse.
//   If ready_i=1 in the delivery cycle, the old byte is consumed, the new byte is loaded, valid_o stays 1, no overrun.
//  Error pulses are exactly 1 cycle and mutually exclusive per frame; overrun may coincide with none of them.
//  Reset mid-frame: frame abandoned, no pulses, valid_o cleared, restart at ARM.
//  The sampled value is uart_rxd_r_i directly; no majority vote is applied.
// TESTING (CLK_FREQ=160, BAUD_RATE=10 -> CLKS_PER_BIT=16, DATA_BITS=8)
//  1 Reset, line held low 50 cycles, then high -> no valid_o until frame;
//    then frame 0xA5 -> data_o=0xA5, valid_o one cycle after the stop sample (8+9*16+1 = 153 cycles after edge).
//  2 Low glitch of 5 cycles on idle line -> START returns to IDLE, no valid_o, no error pulses.
//  3 Frame 0x3C with stop bit low -> frame_err_o 1 cycle, valid_o stays 0, next frame 0x11 (after line high) received.
//  4 PARITY_EN=1, PARITY_ODD=0: frame 0x07 with parity bit 0 -> parity_err_o pulse, no valid_o;
//    same frame with parity bit 1 -> data_o=0x07.
//  5 Send 0x01 and 0x02 back-to-back with ready_i=0 -> data_o=0x01 held, overrun_o pulse at 2nd delivery;
//    repeat with ready_i=1 only at 2nd delivery cycle -> data_o=0x02, no overrun.
//  6 Assert rst_i at bit 4 of frame 0xFF -> outputs zero immediately, state ARM; next clean frame 0x55 -> data_o=0x55.

Source files
------------

// File: rtl/is_uart_rx_ctrl.sv
// Receive-side UART controller: finds the start bit, samples data/parity/stop at mid-bit,
// assembles LSB-first bytes and hands them out on a single-entry valid/ready register.
module is_uart_rx_ctrl #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 uart_rxd_r_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_ARM    = 3'd0,
    S_IDLE   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  // Handshake: data_o is transferred in any cycle where valid_o & ready_i are both high;
  // valid_o then drops on the following edge unless a new byte is loaded in that same cycle.

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_mis_q, par_mis_d;
  logic                   rxd_prev_q;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;
  logic                   deliver;
  logic                   tick;
  logic [CNT_W-1:0]       tgt;

  // The start bit is checked half a bit in, so every later sample lands mid-bit.
  always_comb begin
    tgt = CNT_W'(CLKS_PER_BIT - 1);
    if (state_q == S_START) tgt = CNT_W'(HALF_BIT - 1);
  end

  assign tick = (cnt_q == tgt);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_mis_d    = par_mis_q;
    deliver      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      S_ARM: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (uart_rxd_r_i) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        par_mis_d = 1'b0;
        if (rxd_prev_q && !uart_rxd_r_i) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = uart_rxd_r_i ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt_q == BIT_W'(i)) shift_d[i] = uart_rxd_r_i;
          end
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d     = '0;
          par_mis_d = uart_rxd_r_i ^ (^shift_q) ^ (PARITY_ODD != 0);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d = '0;
          // A low stop bit means we lost framing; re-arm until the line is seen high.
          if (!uart_rxd_r_i) begin
            frame_err_d = 1'b1;
            state_d     = S_ARM;
          end else if (par_mis_q) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_ARM;
      end
    endcase
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (valid_q && ready_i) valid_d = 1'b0;
    // A byte arriving while the old one is still unconsumed is dropped.
    if (deliver) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_ARM;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_mis_q    <= 1'b0;
      rxd_prev_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_mis_q    <= par_mis_d;
      rxd_prev_q   <= uart_rxd_r_i;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != S_ARM) && (state_q != S_IDLE);

endmodule

// File: tb/tb_is_uart_rx_ctrl.sv
// Bench for is_uart_rx_ctrl: one instance without parity (lane 0), one with even parity (lane 1).
module tb_is_uart_rx_ctrl;
  localparam int CPB  = 16;
  localparam int LAT0 = CPB / 2 + (8 + 0 + 1) * CPB + 1;
  localparam int LAT1 = CPB / 2 + (8 + 1 + 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst, rxd, rxd_p, ready, ready_p;
  logic [7:0] data, data_p;
  logic       valid, fe, pe, ov, busy;
  logic       valid_p, fe_p, pe_p, ov_p, busy_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  is_uart_rx_ctrl #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk_i(clk), .rst_i(rst), .uart_rxd_r_i(rxd), .data_o(data), .valid_o(valid), .ready_i(ready),
    .frame_err_o(fe), .parity_err_o(pe), .overrun_o(ov), .busy_o(busy));

  is_uart_rx_ctrl #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk_i(clk), .rst_i(rst), .uart_rxd_r_i(rxd_p), .data_o(data_p), .valid_o(valid_p), .ready_i(ready_p),
    .frame_err_o(fe_p), .parity_err_o(pe_p), .overrun_o(ov_p), .busy_o(busy_p));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event recorders: cycle stamps of pulses and valid rises, plus bytes actually transferred
  int fe_t[$], pe_t[$], ov_t[$], vr_t[$];
  int fe_pt[$], pe_pt[$], ov_pt[$], vr_pt[$];
  logic [7:0] acc_q[$], acc_pq[$];
  logic valid_last = 1'b0, valid_p_last = 1'b0;

  always @(negedge clk) begin
    if (fe) fe_t.push_back(cyc);
    if (pe) pe_t.push_back(cyc);
    if (ov) ov_t.push_back(cyc);
    if (valid && !valid_last) vr_t.push_back(cyc);
    if (valid && ready) acc_q.push_back(data);
    valid_last = valid;
    if (fe_p) fe_pt.push_back(cyc);
    if (pe_p) pe_pt.push_back(cyc);
    if (ov_p) ov_pt.push_back(cyc);
    if (valid_p && !valid_p_last) vr_pt.push_back(cyc);
    if (valid_p && ready_p) acc_pq.push_back(data_p);
    valid_p_last = valid_p;
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    fe_t.delete(); pe_t.delete(); ov_t.delete(); vr_t.delete(); acc_q.delete();
    fe_pt.delete(); pe_pt.delete(); ov_pt.delete(); vr_pt.delete(); acc_pq.delete();
  endtask

  task automatic set_line(input int lane, input logic v);
    if (lane == 0) rxd = v;
    else rxd_p = v;
  endtask

  task automatic send_frame(input int lane, input logic [7:0] d, input logic par, input logic stop,
                            output int t0);
    t0 = cyc;
    set_line(lane, 1'b0);
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      set_line(lane, d[i]);
      wait_cyc(CPB);
    end
    if (lane == 1) begin
      set_line(lane, par);
      wait_cyc(CPB);
    end
    set_line(lane, stop);
    wait_cyc(CPB);
    set_line(lane, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(3);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data got %0h expected 0", data); end
    checks++; if ({valid, fe, pe, ov, busy} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b expected 00000", {valid, fe, pe, ov, busy}); end
    checks++; if ({data_p, valid_p, fe_p, pe_p, ov_p, busy_p} !== 13'b0) begin errors++; $display("FAIL rst_p got %h expected 0", {data_p, valid_p, fe_p, pe_p, ov_p, busy_p}); end
    rst = 1'b0;
  endtask

  task automatic test_arm_then_frame();
    int t0;
    clear_mon();
    wait_cyc(50);
    checks++; if (busy !== 1'b0 || vr_t.size() != 0) begin errors++; $display("FAIL arm_low got busy=%b vr=%0d expected 0 0", busy, vr_t.size()); end
    rxd = 1'b1;
    wait_cyc(3);
    send_frame(0, 8'hA5, 1'b0, 1'b1, t0);
    wait_cyc(3);
    checks++; if (((vr_t.size() == 1) ? vr_t[0] : -1) != t0 + LAT0) begin errors++; $display("FAIL a5_latency got %0d expected %0d", (vr_t.size() == 1) ? vr_t[0] - t0 : -1, LAT0); end
    checks++; if (data !== 8'hA5 || valid !== 1'b1) begin errors++; $display("FAIL a5_data got %0h/%b expected a5/1", data, valid); end
    checks++; if (fe_t.size() + pe_t.size() + ov_t.size() != 0) begin errors++; $display("FAIL a5_pulses got %0d expected 0", fe_t.size() + pe_t.size() + ov_t.size()); end
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL a5_consume got %b expected 0", valid); end
    checks++; if (((acc_q.size() == 1) ? acc_q[0] : 8'hxx) !== 8'hA5) begin errors++; $display("FAIL a5_accept got %0d bytes expected 1", acc_q.size()); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rxd = 1'b0;
    wait_cyc(3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b expected 1", busy); end
    wait_cyc(2);
    rxd = 1'b1;
    wait_cyc(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b expected 0", busy); end
    wait_cyc(170);
    checks++; if (vr_t.size() + fe_t.size() + pe_t.size() + ov_t.size() != 0) begin errors++; $display("FAIL glitch_events got %0d expected 0", vr_t.size() + fe_t.size() + pe_t.size() + ov_t.size()); end
  endtask

  task automatic test_frame_error();
    int t0, t1;
    clear_mon();
    send_frame(0, 8'h3C, 1'b0, 1'b0, t0);
    wait_cyc(2);
    checks++; if (((fe_t.size() == 1) ? fe_t[0] : -1) != t0 + LAT0) begin errors++; $display("FAIL fe_pulse got %0d pulses expected 1 at +%0d", fe_t.size(), LAT0); end
    checks++; if (valid !== 1'b0 || vr_t.size() + pe_t.size() + ov_t.size() != 0) begin errors++; $display("FAIL fe_side got valid=%b events=%0d expected 0 0", valid, vr_t.size() + pe_t.size() + ov_t.size()); end
    wait_cyc(3);
    send_frame(0, 8'h11, 1'b0, 1'b1, t1);
    wait_cyc(3);
    checks++; if (((vr_t.size() == 1) ? vr_t[0] : -1) != t1 + LAT0 || data !== 8'h11) begin errors++; $display("FAIL fe_next got %0h expected 11", data); end
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
  endtask

  task automatic test_parity();
    int t0, t1;
    clear_mon();
    send_frame(1, 8'h07, 1'b0, 1'b1, t0);
    wait_cyc(3);
    checks++; if (((pe_pt.size() == 1) ? pe_pt[0] : -1) != t0 + LAT1) begin errors++; $display("FAIL par_pulse got %0d pulses expected 1 at +%0d", pe_pt.size(), LAT1); end
    checks++; if (valid_p !== 1'b0 || vr_pt.size() + fe_pt.size() != 0) begin errors++; $display("FAIL par_side got valid=%b expected 0", valid_p); end
    wait_cyc(2);
    send_frame(1, 8'h07, 1'b1, 1'b1, t1);
    wait_cyc(3);
    checks++; if (((vr_pt.size() == 1) ? vr_pt[0] : -1) != t1 + LAT1) begin errors++; $display("FAIL par_latency got %0d rises expected 1 at +%0d", vr_pt.size(), LAT1); end
    checks++; if (data_p !== 8'h07 || pe_pt.size() != 1) begin errors++; $display("FAIL par_data got %0h expected 07", data_p); end
    ready_p = 1'b1;
    wait_cyc(1);
    ready_p = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t1, t2, t3, t4;
    clear_mon();
    ready = 1'b0;
    send_frame(0, 8'h01, 1'b0, 1'b1, t1);
    send_frame(0, 8'h02, 1'b0, 1'b1, t2);
    wait_cyc(3);
    checks++; if (((ov_t.size() == 1) ? ov_t[0] : -1) != t2 + LAT0) begin errors++; $display("FAIL ovr_pulse got %0d pulses expected 1", ov_t.size()); end
    checks++; if (data !== 8'h01 || valid !== 1'b1) begin errors++; $display("FAIL ovr_hold got %0h expected 01", data); end
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got %b expected 0", valid); end
    clear_mon();
    send_frame(0, 8'h01, 1'b0, 1'b1, t3);
    fork
      send_frame(0, 8'h02, 1'b0, 1'b1, t4);
      begin
        wait_cyc(LAT0 - 1);
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
      end
    join
    wait_cyc(2);
    checks++; if (data !== 8'h02 || valid !== 1'b1) begin errors++; $display("FAIL b2b_data got %0h/%b expected 02/1", data, valid); end
    checks++; if (ov_t.size() != 0) begin errors++; $display("FAIL b2b_overrun got %0d expected 0", ov_t.size()); end
    checks++; if (((acc_q.size() == 1) ? acc_q[0] : 8'hxx) !== 8'h01) begin errors++; $display("FAIL b2b_accept got %0d bytes expected 1 (01)", acc_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int t1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %b expected 1", valid); end
    clear_mon();
    rxd = 1'b0;
    wait_cyc(CPB);
    rxd = 1'b1;
    wait_cyc(4 * CPB + CPB / 2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({data, valid, busy} !== 10'b0) begin errors++; $display("FAIL mid_reset got %h expected 0", {data, valid, busy}); end
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    checks++; if (fe_t.size() + pe_t.size() + ov_t.size() + vr_t.size() != 0) begin errors++; $display("FAIL mid_events got %0d expected 0", fe_t.size() + pe_t.size() + ov_t.size() + vr_t.size()); end
    send_frame(0, 8'h55, 1'b0, 1'b1, t1);
    wait_cyc(3);
    checks++; if (((vr_t.size() == 1) ? vr_t[0] : -1) != t1 + LAT0 || data !== 8'h55) begin errors++; $display("FAIL mid_next got %0h expected 55", data); end
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
  endtask

  // scoreboard: expected bytes from frame rules (low stop -> framing, bad even parity -> parity)
  task automatic test_random();
    logic [7:0] exp_q[$], exp_pq[$];
    int nfe = 0, npe = 0, nfe_p = 0, t0;
    clear_mon();
    ready = 1'b1;
    ready_p = 1'b1;
    for (int n = 0; n < 16; n++) begin
      int lane;
      logic [7:0] d;
      logic par, stop;
      lane = $urandom_range(0, 1);
      d    = 8'($urandom);
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      if (!stop) begin
        if (lane == 0) nfe++; else nfe_p++;
      end else if (lane == 1 && par != ($countones(d) % 2 == 1)) npe++;
      else if (lane == 0) exp_q.push_back(d);
      else exp_pq.push_back(d);
      send_frame(lane, d, par, stop, t0);
      wait_cyc($urandom_range(2, 20));
    end
    wait_cyc(3);
    ready = 1'b0;
    ready_p = 1'b0;
    checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count0 got %0d expected %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_byte0[%0d] got %0h expected %0h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (acc_pq.size() != exp_pq.size()) begin errors++; $display("FAIL rnd_count1 got %0d expected %0d", acc_pq.size(), exp_pq.size()); end
    for (int i = 0; i < exp_pq.size() && i < acc_pq.size(); i++) begin
      checks++; if (acc_pq[i] !== exp_pq[i]) begin errors++; $display("FAIL rnd_byte1[%0d] got %0h expected %0h", i, acc_pq[i], exp_pq[i]); end
    end
    checks++; if (fe_t.size() != nfe || fe_pt.size() != nfe_p) begin errors++; $display("FAIL rnd_frame_err got %0d/%0d expected %0d/%0d", fe_t.size(), fe_pt.size(), nfe, nfe_p); end
    checks++; if (pe_pt.size() != npe || pe_t.size() != 0) begin errors++; $display("FAIL rnd_parity_err got %0d expected %0d", pe_pt.size(), npe); end
    checks++; if (ov_t.size() + ov_pt.size() != 0) begin errors++; $display("FAIL rnd_overrun got %0d expected 0", ov_t.size() + ov_pt.size()); end
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b0;
    rxd_p = 1'b1;
    ready = 1'b0;
    ready_p = 1'b0;
    #1;
    test_reset();
    test_arm_then_frame();
    test_glitch();
    test_frame_error();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
